mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-ported core `memory` block between the instruction-fetch and load/store units of the RISC-V core. It grants one requester at a time and sequences the memory's one-cycle registered read latency and single-cycle byte-masked write. It returns data with a one-cycle acknowledge pulse and rejects out-of-range addresses without touching memory. It sits between the core's fetch/LSU and `memory`, driving all of `memory`'s inputs.

## Interface
- `SIZE`, default `` `MEM_SIZE ``: memory size in bytes; any address `>= SIZE` is an error.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: reset, asynchronous, active-high.
- `i_req_i  in  1`: fetch request; held until `i_ack_o`.
- `i_addr_i  in  32`: fetch byte address; held until `i_ack_o`.
- `i_ack_o  out  1`: one-cycle completion pulse.
- `i_err_o  out  1`: qualifies `i_ack_o`; set when the address was out of range.
- `i_rdata_o  out  32`: fetch data; valid only while `i_ack_o` is high.
- `d_req_i  in  1`: load/store request; held until `d_ack_o`.
- `d_addr_i  in  32`: load/store byte address.
- `d_wmask_i  in  4`: byte write enables; `0` means load, non-zero means store.
- `d_wdata_i  in  32`: store data.
- `d_ack_o`, `d_err_o`, `d_rdata_o`: same rules as the `i_` outputs.
- `mem_addr_o  out  32`: to `memory`.
- `mem_rstrb_o  out  1`: to `memory`.
- `mem_wmask_o  out  4`: to `memory`.
- `mem_wdata_o  out  32`: to `memory`.
- `mem_rdata_i  in  32`: from `memory`; valid the cycle after `mem_rstrb_o`.

## Operation
- FSM states:
  - `IDLE`: arbitrate. If any request is pending, latch the winner's id, addr, wmask and wdata, then go to `ISSUE`.
  - `ISSUE`: drive `memory` from the latched copy.
    - Out of range: no strobe and no mask; assert ack+err; go to `IDLE`.
    - Store: `mem_wmask_o` = latched mask; assert ack; go to `IDLE`.
    - Load/fetch: assert `mem_rstrb_o`; go to `RESP`.
  - `RESP`: assert ack; `*_rdata_o` = `mem_rdata_i`; go to `IDLE`.
- Fetch requests are always reads.
- `mem_rstrb_o` and `mem_wmask_o` are nonzero only in `ISSUE`. They are decoded from the state register, so reset forces them to 0 immediately.
- Ack, err and rdata are routed only to the granted requester. The other requester's outputs stay 0. Rdata is 0 whenever ack is low or err is set.
- Range check: latched address `>= SIZE` gives an error. Address bits [1:0] are ignored; the store byte lanes come from the wmask.
- Requesters may drop or change their request at the edge after their ack. `IDLE` samples requests in the cycle after an ack.
- Reset values: state `IDLE`, all outputs 0, latched fields 0, last-grant = data.
- Reset mid-transaction: the access is aborted and no ack is issued. A store in `ISSUE` does not commit if `rst` rises before the edge.

## Timing
- Request seen in `IDLE` at cycle N; memory is driven in cycle N+1.
- Store or error: ack at N+1, so latency is 2 cycles.
- Load or fetch: ack at N+2 with data, so latency is 3 cycles.
- Back-to-back: the next `IDLE` is at N+2 (store) or N+3 (load). Peak throughput is one access per 2 or 3 cycles.
- Simultaneous requests in `IDLE` are resolved by the arbitration policy (see Configuration). The loser keeps its request high and is granted at the next `IDLE`.
- Requests arriving in `ISSUE` or `RESP` wait for `IDLE`.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. On a tie, the requester not granted last wins. Last-grant resets to data, so fetch wins the first tie.
- Not defined: fixed priority, data over fetch on every tie. The last-grant register is not built.

## Structure
- `mem_arb_pkg` holds:
  - state enum `IDLE` / `ISSUE` / `RESP`;
  - grant enum `GNT_I` / `GNT_D`;
  - constants `WORD_W = 32` and `MASK_W = 4`.
- One sub-module, `mem_arb_sel`: combinational 2-way selector. Inputs are the two requests, the last grant and the policy. Output is the grant id. It owns both policies under `MEM_ARB_RR_EN`.
- FSM, latches and output muxing live in `mem_arbiter`.

## Test plan
- Fetch only: `i_addr_i` = 0x10, memory word 4 = 0xDEADBEEF. Expect `mem_rstrb_o` one cycle after the request, then `i_ack_o` with `i_rdata_o` = 0xDEADBEEF at N+2. `d_ack_o` stays 0.
- Store then load: store wmask 4'b0011, data 0x12345678 to 0x20, over an old value of 0xFFFFFFFF. Expect `d_ack_o` at N+1. Then load 0x20: `d_rdata_o` = 0xFFFF5678.
- Simultaneous requests:
  - Without `MEM_ARB_RR_EN`: data is granted first, then fetch.
  - With `MEM_ARB_RR_EN`: fetch first, then data, then fetch again on a repeated tie.
- Out of range, with `SIZE` = 1024: load at 0x400. Expect `d_ack_o` and `d_err_o` at N+1, rdata 0, `mem_rstrb_o` never asserted.
- Reset: assert `rst` asynchronously during a store's `ISSUE` cycle. Expect `mem_wmask_o` to drop to 0 immediately, the target word unchanged, no ack, and state `IDLE`.
- Starvation check, round-robin: both requests held high for 20 accesses. Expect acks to alternate exactly.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the two-port memory arbiter.
// Round-robin policy is selected with MEM_ARB_RR_EN.
package mem_arb_pkg;

  localparam int WORD_W = 32;
  localparam int MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  typedef enum logic {
    GNT_I,
    GNT_D
  } gnt_e;

endpackage

// File: rtl/mem_arb_sel.sv
// Two-way grant selector for the memory arbiter.
// MEM_ARB_RR_EN: round-robin on ties, else data wins every tie.
module mem_arb_sel
  import mem_arb_pkg::*;
(
  input  logic i_ireq,
  input  logic i_dreq,
  input  gnt_e i_last,
  output gnt_e o_gnt
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    o_gnt = GNT_D;
    if (i_ireq && i_dreq) begin
      o_gnt = (i_last == GNT_D) ? GNT_I : GNT_D;
    end else if (i_ireq) begin
      o_gnt = GNT_I;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = (i_last == GNT_D);

  always_comb begin
    o_gnt = GNT_D;
    if (i_ireq && !i_dreq) begin
      o_gnt = GNT_I;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/LSU arbiter in front of the single-ported core memory.
// MEM_ARB_RR_EN selects round-robin; default is fixed data priority.
`ifndef MEM_SIZE
`define MEM_SIZE 1024
`endif

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned SIZE = `MEM_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_i,
  input  logic [WORD_W-1:0] i_addr_i,
  output logic              i_ack_o,
  output logic              i_err_o,
  output logic [WORD_W-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic [WORD_W-1:0] d_addr_i,
  input  logic [MASK_W-1:0] d_wmask_i,
  input  logic [WORD_W-1:0] d_wdata_i,
  output logic              d_ack_o,
  output logic              d_err_o,
  output logic [WORD_W-1:0] d_rdata_o,
  output logic [WORD_W-1:0] mem_addr_o,
  output logic              mem_rstrb_o,
  output logic [MASK_W-1:0] mem_wmask_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  input  logic [WORD_W-1:0] mem_rdata_i
);

  state_e            r_state;
  state_e            w_next;
  gnt_e              r_gnt;
  gnt_e              w_gnt;
  gnt_e              w_last;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [MASK_W-1:0] r_wmask;
  logic [WORD_W-1:0] w_rdata;
  logic              w_any;
  logic              w_take;
  logic              w_err;
  logic              w_ack;

  assign w_any  = i_req_i | d_req_i;
  assign w_take = (r_state == IDLE) && w_any;
  assign w_err  = {r_addr[WORD_W-1:2], 2'b00} >= SIZE;

`ifdef MEM_ARB_RR_EN
  gnt_e r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= GNT_D;
    end else if (w_take) begin
      r_last <= w_gnt;
    end
  end

  assign w_last = r_last;
`else
  assign w_last = GNT_D;
`endif

  mem_arb_sel u_sel (
    .i_ireq (i_req_i),
    .i_dreq (d_req_i),
    .i_last (w_last),
    .o_gnt  (w_gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Fetches latch a zero mask so they always take the read path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt   <= GNT_I;
      r_addr  <= '0;
      r_wmask <= '0;
      r_wdata <= '0;
    end else if (w_take) begin
      r_gnt <= w_gnt;
      if (w_gnt == GNT_D) begin
        r_addr  <= d_addr_i;
        r_wmask <= d_wmask_i;
        r_wdata <= d_wdata_i;
      end else begin
        r_addr  <= i_addr_i;
        r_wmask <= '0;
        r_wdata <= '0;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_ack       = 1'b0;
    mem_rstrb_o = 1'b0;
    mem_wmask_o = '0;
    unique case (r_state)
      IDLE: begin
        if (w_any) w_next = ISSUE;
      end
      ISSUE: begin
        w_next = IDLE;
        if (w_err) begin
          w_ack = 1'b1;
        end else if (|r_wmask) begin
          mem_wmask_o = r_wmask;
          w_ack       = 1'b1;
        end else begin
          mem_rstrb_o = 1'b1;
          w_next      = RESP;
        end
      end
      RESP: begin
        w_next = IDLE;
        w_ack  = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign w_rdata     = (r_state == RESP) ? mem_rdata_i : '0;

  assign i_ack_o   = w_ack && (r_gnt == GNT_I);
  assign i_err_o   = w_ack && w_err && (r_gnt == GNT_I);
  assign i_rdata_o = (r_gnt == GNT_I) ? w_rdata : '0;
  assign d_ack_o   = w_ack && (r_gnt == GNT_D);
  assign d_err_o   = w_ack && w_err && (r_gnt == GNT_D);
  assign d_rdata_o = (r_gnt == GNT_D) ? w_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural memory.
// Build with MEM_ARB_RR_EN to check the round-robin policy.
module tb_mem_arbiter;

  localparam int SIZE = 1024;
  localparam int NW   = SIZE / 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_i = 1'b0;
  logic [31:0] i_addr_i = '0;
  logic        i_ack_o, i_err_o;
  logic [31:0] i_rdata_o;
  logic        d_req_i = 1'b0;
  logic [31:0] d_addr_i = '0;
  logic [3:0]  d_wmask_i = '0;
  logic [31:0] d_wdata_i = '0;
  logic        d_ack_o, d_err_o;
  logic [31:0] d_rdata_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_rstrb_o;
  logic [3:0]  mem_wmask_o;
  logic [31:0] mem_rdata_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i),
    .i_ack_o(i_ack_o), .i_err_o(i_err_o), .i_rdata_o(i_rdata_o),
    .d_req_i(d_req_i), .d_addr_i(d_addr_i),
    .d_wmask_i(d_wmask_i), .d_wdata_i(d_wdata_i),
    .d_ack_o(d_ack_o), .d_err_o(d_err_o), .d_rdata_o(d_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_rstrb_o(mem_rstrb_o),
    .mem_wmask_o(mem_wmask_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  function automatic logic [31:0] init_word(int k);
    logic [31:0] kk;
    kk = k;
    if (k == 4) return 32'hDEADBEEF;
    if (k == 8) return 32'hFFFFFFFF;
    return kk * 32'h9E3779B1 + 32'h1234;
  endfunction

  // Memory device: registered read, byte-masked write, preload on init_en.
  logic [31:0] mem [NW];
  logic        init_en = 1'b1;

  always @(posedge clk) begin
    if (init_en) begin
      for (int k = 0; k < NW; k++) mem[k] <= init_word(k);
    end else begin
      if (mem_rstrb_o) mem_rdata_i <= mem[mem_addr_o[9:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wmask_o[b])
          mem[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    end
  end

  // Reference model: a word array updated per access.
  logic [31:0] ref_mem [NW];

  task automatic ref_access(input bit is_d, input logic [31:0] a,
                            input logic [3:0] wm, input logic [31:0] wd,
                            output bit err, output logic [31:0] rd,
                            output int lat);
    int idx;
    err = (a >= SIZE);
    rd  = '0;
    lat = 1;
    if (!err) begin
      idx = int'(a / 4);
      if (is_d && wm != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (wm[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        rd  = ref_mem[idx];
        lat = 2;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_txn(input bit is_d, input logic [31:0] a,
                        input logic [3:0] wm, input logic [31:0] wd,
                        output int lat, output bit err,
                        output logic [31:0] rd, output bit other,
                        output int strb_cyc);
    @(posedge clk); #1;
    lat = 99; err = 0; rd = '0; other = 0; strb_cyc = 0;
    if (is_d) begin
      d_req_i = 1; d_addr_i = a; d_wmask_i = wm; d_wdata_i = wd;
    end else begin
      i_req_i = 1; i_addr_i = a;
    end
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (mem_rstrb_o && strb_cyc == 0) strb_cyc = c;
      if (is_d ? i_ack_o : d_ack_o) other = 1;
      if (is_d ? d_ack_o : i_ack_o) begin
        lat = c;
        err = is_d ? d_err_o : i_err_o;
        rd  = is_d ? d_rdata_o : i_rdata_o;
        break;
      end
    end
    i_req_i = 0;
    d_req_i = 0;
  endtask

  task automatic run_chk(input string nm, input bit is_d,
                         input logic [31:0] a, input logic [3:0] wm,
                         input logic [31:0] wd, input bit e_err,
                         input logic [31:0] e_rd, input int e_lat);
    int lat, sc;
    bit err, oth;
    logic [31:0] rd;
    do_txn(is_d, a, wm, wd, lat, err, rd, oth, sc);
    chk({nm, ".lat"}, lat, e_lat);
    chk({nm, ".err"}, err, e_err);
    chk({nm, ".rdata"}, rd, e_rd);
    chk({nm, ".other_ack"}, oth, 0);
    chk({nm, ".rstrb_cyc"}, sc, (e_lat == 2) ? 1 : 0);
  endtask

  task automatic run_ref(input string nm, input bit is_d,
                         input logic [31:0] a, input logic [3:0] wm,
                         input logic [31:0] wd);
    bit e; logic [31:0] r; int l;
    ref_access(is_d, a, wm, wd, e, r, l);
    run_chk(nm, is_d, a, wm, wd, e, r, l);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, ".ctl"}, {i_ack_o, i_err_o, d_ack_o, d_err_o,
                       mem_rstrb_o, mem_wmask_o}, 0);
    chk({nm, ".i_rdata"}, i_rdata_o, 0);
    chk({nm, ".d_rdata"}, d_rdata_o, 0);
    chk({nm, ".mem_addr"}, mem_addr_o, 0);
    chk({nm, ".mem_wdata"}, mem_wdata_o, 0);
  endtask

  task automatic do_reset(input string nm);
    i_req_i = 0;
    d_req_i = 0;
    #1 rst = 1;
    #1 chk_reset_outs(nm);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
  endtask

  // Both requesters contend: fetch at 0x10, load at 0x20.
  task automatic contend(input string nm, input bit hold, input int n);
    bit pi, pd, last_d, exp_d, rr;
    int got;
`ifdef MEM_ARB_RR_EN
    rr = 1;
`else
    rr = 0;
`endif
    @(posedge clk); #1;
    i_req_i = 1; i_addr_i = 32'h10;
    d_req_i = 1; d_addr_i = 32'h20; d_wmask_i = 4'h0;
    pi = 1; pd = 1; last_d = 1; got = 0;
    for (int c = 0; c < 4 * n + 4; c++) begin
      @(posedge clk); #1;
      if (i_ack_o && d_ack_o) chk({nm, ".dual_ack"}, 1, 0);
      if (i_ack_o || d_ack_o) begin
        exp_d = (pi && pd) ? (rr ? !last_d : 1'b1) : pd;
        chk({nm, ".gnt_d"}, d_ack_o, exp_d);
        if (d_ack_o) chk({nm, ".d_rdata"}, d_rdata_o, ref_mem[8]);
        else         chk({nm, ".i_rdata"}, i_rdata_o, ref_mem[4]);
        last_d = d_ack_o;
        got++;
        if (!hold) begin
          if (d_ack_o) begin pd = 0; d_req_i = 0; end
          else         begin pi = 0; i_req_i = 0; end
        end
        if (hold && got == n) break;
        if (!pi && !pd) break;
      end
    end
    i_req_i = 0;
    d_req_i = 0;
    chk({nm, ".count"}, got, hold ? n : 2);
  endtask

  typedef struct {
    bit          is_d;
    logic [31:0] a;
    logic [3:0]  wm;
    logic [31:0] wd;
    bit          e_err;
    logic [31:0] e_rd;
    int          e_lat;
  } vec_t;

  vec_t vt [9];

  initial begin
    bit          e;
    logic [31:0] r;
    int          l;
    bit          rd_is_d;
    logic [31:0] ra;
    logic [3:0]  rwm;

    for (int k = 0; k < NW; k++) ref_mem[k] = init_word(k);
    vt[0] = '{0, 32'h10,  4'h0, 32'h0,        0, 32'hDEADBEEF, 2};
    vt[1] = '{1, 32'h20,  4'h3, 32'h12345678, 0, 32'h0,        1};
    vt[2] = '{1, 32'h20,  4'h0, 32'h0,        0, 32'hFFFF5678, 2};
    vt[3] = '{1, 32'h400, 4'h0, 32'h0,        1, 32'h0,        1};
    vt[4] = '{0, 32'h400, 4'h0, 32'h0,        1, 32'h0,        1};
    vt[5] = '{1, 32'h3FC, 4'hF, 32'hA5A5A5A5, 0, 32'h0,        1};
    vt[6] = '{0, 32'h3FF, 4'h0, 32'h0,        0, 32'hA5A5A5A5, 2};
    vt[7] = '{1, 32'h500, 4'hF, 32'h11111111, 1, 32'h0,        1};
    vt[8] = '{1, 32'h23,  4'h0, 32'h0,        0, 32'hFFFF5678, 2};

    repeat (2) @(posedge clk);
    #1 init_en = 0;
    chk_reset_outs("reset");
    @(negedge clk) rst = 0;

    for (int v = 0; v < 9; v++) begin
      ref_access(vt[v].is_d, vt[v].a, vt[v].wm, vt[v].wd, e, r, l);
      run_chk($sformatf("vec%0d", v), vt[v].is_d, vt[v].a, vt[v].wm,
              vt[v].wd, vt[v].e_err, vt[v].e_rd, vt[v].e_lat);
    end

    @(posedge clk); #1;
    d_req_i = 1; d_addr_i = 32'h24; d_wmask_i = 4'hF;
    d_wdata_i = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk("rst_mid.wmask_pre", mem_wmask_o, 4'hF);
    rst = 1;
    #1;
    chk("rst_mid.wmask", mem_wmask_o, 0);
    chk("rst_mid.ack", d_ack_o, 0);
    d_req_i = 0;
    @(posedge clk); #1;
    chk("rst_mid.ack2", d_ack_o, 0);
    chk("rst_mid.word", mem[9], ref_mem[9]);
    @(negedge clk) rst = 0;
    run_ref("rst_mid.load", 1, 32'h24, 4'h0, 32'h0);

    do_reset("rst_tie");
    contend("tie", 0, 2);
    do_reset("rst_starve");
    contend("starve", 1, 20);

    for (int t = 0; t < 40; t++) begin
      rd_is_d = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1024, 1200))
                                       : 32'($urandom_range(0, 1023));
      rwm = (rd_is_d && $urandom_range(0, 1) == 1)
            ? 4'($urandom_range(1, 15)) : 4'h0;
      run_ref($sformatf("rnd%0d", t), rd_is_d, ra, rwm, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
